mfp_adc_max10_responder: RTL and testbench
==========================================

MFP_ADC_MAX10_RESPONDER -- requirements
Module: mfp_adc_max10_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 4, meaning the number of conversion cycles per command; legal range 1..255.
REQ-002 SHALL have parameter MAX_CHANNEL, default 17, meaning the highest valid channel number (MAX10 ADC0 channels 0..16 plus temperature sensor 17).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port command_valid, input, 1 bit: command request from the ADC initiator.
REQ-007 SHALL have port command_channel, input, 5 bits: requested channel.
REQ-008 SHALL have port command_startofpacket, input, 1 bit: command SOP tag.
REQ-009 SHALL have port command_endofpacket, input, 1 bit: command EOP tag.
REQ-010 SHALL have port command_ready, output, 1 bit: responder can take a command this cycle.
REQ-011 SHALL have port response_valid, output, 1 bit: one-cycle result strobe; this interface has no backpressure.
REQ-012 SHALL have port response_channel, output, 5 bits: channel of the result.
REQ-013 SHALL have port response_data, output, 12 bits: conversion result.
REQ-014 SHALL have port response_startofpacket, output, 1 bit: copy of the command SOP tag.
REQ-015 SHALL have port response_endofpacket, output, 1 bit: copy of the command EOP tag.
REQ-016 SHALL have port channel_error, output, 1 bit: sticky flag, set when an out-of-range channel is accepted.

Function
REQ-017 SHALL accept a command on the rising edge where command_valid and command_ready are both 1.
REQ-018 SHALL implement FSM states IDLE, CONVERT and RESPOND.
REQ-019 SHALL move IDLE->CONVERT on accept and load the conversion counter with CONV_CYCLES-1.
REQ-020 SHALL decrement the counter each cycle in CONVERT and move CONVERT->RESPOND on the edge where the counter is 0.
REQ-021 SHALL hold RESPOND for exactly one cycle, then go to CONVERT if a command is pending or just accepted, otherwise to IDLE.
REQ-022 SHALL hold a one-entry pending buffer (channel, SOP, EOP) for commands accepted while in CONVERT or RESPOND.
REQ-023 SHALL drive command_ready as a registered signal equal to "pending buffer empty", so back-to-back accepts are never lost.
REQ-024 SHALL, on accept during RESPOND with an empty buffer, bypass the buffer and start the new conversion on the next cycle.
REQ-025 SHALL, on accept during RESPOND with a full buffer, be impossible (ready is 0); the pending entry starts next.
REQ-026 SHALL drive response_valid=1 only in RESPOND, i.e. CONV_CYCLES+1 cycles after the accepting edge.
REQ-027 SHALL keep back-to-back results spaced by exactly CONV_CYCLES+1 cycles.
REQ-028 SHALL hold the response_channel, SOP, EOP and data registers stable outside the response_valid cycle.
REQ-029 SHALL compute response_data = {channel[4:0], seq[6:0]} for a channel <= MAX_CHANNEL.
REQ-030 SHALL use seq as a 7-bit counter of responses issued, incremented after each response and wrapping from 127 to 0.
REQ-031 SHALL, for a channel > MAX_CHANNEL, respond with response_data=12'h000, still increment seq, and set channel_error.
REQ-032 SHALL clear channel_error only by reset.
REQ-033 SHALL ignore command_valid when command_ready is 0; no state changes.

Reset
REQ-034 SHALL, on resetn=0, asynchronously force state IDLE, counter 0, seq 0, pending buffer empty, and channel_error 0.
REQ-035 SHALL, on resetn=0, drive response_valid 0, response_channel 0, response_data 0, response_startofpacket 0, response_endofpacket 0, and command_ready 0.
REQ-036 SHALL raise command_ready to 1 on the first clk edge after resetn deasserts.
REQ-037 SHALL, when reset arrives mid-conversion, discard the in-flight command and the pending command without issuing a response.

Structure
REQ-038 SHALL place the FSM state encodings, the channel/data widths (5, 12), the seq width (7) and the default MAX_CHANNEL in the shared mfp_adc_max10 package/header used by the system ADC command logic.
REQ-039 SHALL implement the pending buffer as sub-module mfp_adc_cmd_buffer (one-entry, valid flag, registered full).

Verification
REQ-040 SHALL verify single command: ch=3 accepted at edge 0, CONV_CYCLES=4 -> response_valid at cycle 5 only, channel 3, data 12'h180, SOP/EOP copied.
REQ-041 SHALL verify back-to-back commands: ch=1 then ch=2 held valid -> second accepted the cycle after the first, ready drops, responses 5 cycles apart with data 12'h080 then 12'h101.
REQ-042 SHALL verify an invalid channel: ch=20 -> response data 12'h000, channel 20, channel_error=1 and still 1 after a later valid command.
REQ-043 SHALL verify seq wrap: 129 commands on ch=0 -> response 128 data 12'h07F, response 129 data 12'h000.
REQ-044 SHALL verify reset mid-op: resetn low 2 cycles into CONVERT with a pending entry -> no response, outputs 0, ready=1 one edge after release, next response seq=0.
REQ-045 SHALL verify CONV_CYCLES=1: ch=17 -> response 2 cycles after accept, data 12'h880, channel_error stays 0.

Source files
------------

// File: rtl/mfp_adc_max10_pkg.sv
// Shared definitions for the MAX10 ADC command/response logic: widths,
// FSM encodings, command record and the result-word formatter.
package mfp_adc_max10_pkg;

   localparam int CH_W            = 5;
   localparam int DATA_W          = 12;
   localparam int SEQ_W           = 7;
   localparam int CNT_W           = 8;
   localparam int DEF_MAX_CHANNEL = 17;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_RESPOND = 2'd2
   } adc_state_e;

   typedef struct packed {
      logic [CH_W-1:0] channel;
      logic            sop;
      logic            eop;
   } adc_cmd_t;

   // Out-of-range channels report an all-zero result word.
   function automatic logic [DATA_W-1:0] rsp_word(
      input logic [CH_W-1:0]  ch,
      input logic [SEQ_W-1:0] seq,
      input logic             ch_ok
   );
      return ch_ok ? {ch, seq} : '0;
   endfunction

endpackage

// File: rtl/mfp_adc_cmd_buffer.sv
// One-entry holding register for a command accepted while a conversion is
// in flight; full is the registered valid flag.
module mfp_adc_cmd_buffer
   import mfp_adc_max10_pkg::*;
(
   input  logic     clk,
   input  logic     resetn,
   input  logic     push,
   input  adc_cmd_t push_cmd,
   input  logic     pop,
   output logic     full,
   output logic     full_next,
   output adc_cmd_t head
);

   logic     full_q, full_d;
   adc_cmd_t cmd_q, cmd_d;

   always_comb begin
      full_d = full_q;
      cmd_d  = cmd_q;
      if (pop) begin
         full_d = 1'b0;
      end
      if (push) begin
         full_d = 1'b1;
         cmd_d  = push_cmd;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         full_q <= 1'b0;
         cmd_q  <= '0;
      end else begin
         full_q <= full_d;
         cmd_q  <= cmd_d;
      end
   end

   assign full      = full_q;
   assign full_next = full_d;
   assign head      = cmd_q;

endmodule

// File: rtl/mfp_adc_max10_responder.sv
// MAX10 ADC command/response model: fixed-latency conversions with a
// one-deep command queue, sequence-tagged results and a sticky range error.
//
// state      | meaning
// IDLE       | no command in flight, waiting for an accept
// CONVERT    | counting down the conversion of the active command
// RESPOND    | single-cycle result strobe, then next command or IDLE
module mfp_adc_max10_responder
   import mfp_adc_max10_pkg::*;
#(
   parameter int CONV_CYCLES = 4,
   parameter int MAX_CHANNEL = DEF_MAX_CHANNEL
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              command_valid,
   input  logic [CH_W-1:0]   command_channel,
   input  logic              command_startofpacket,
   input  logic              command_endofpacket,
   output logic              command_ready,
   output logic              response_valid,
   output logic [CH_W-1:0]   response_channel,
   output logic [DATA_W-1:0] response_data,
   output logic              response_startofpacket,
   output logic              response_endofpacket,
   output logic              channel_error
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CH_W-1:0]  MAX_CH   = CH_W'(MAX_CHANNEL);

   adc_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   adc_cmd_t          act_q, act_d;
   adc_cmd_t          cmd_in, buf_head;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [CH_W-1:0]   rsp_ch_q, rsp_ch_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_sop_q, rsp_sop_d;
   logic              rsp_eop_q, rsp_eop_d;
   logic              accept, buf_push, buf_pop, buf_full, buf_full_next;

   assign cmd_in = {command_channel, command_startofpacket, command_endofpacket};
   assign accept = command_valid & ready_q;

   mfp_adc_cmd_buffer u_cmd_buffer (
      .clk       (clk),
      .resetn    (resetn),
      .push      (buf_push),
      .push_cmd  (cmd_in),
      .pop       (buf_pop),
      .full      (buf_full),
      .full_next (buf_full_next),
      .head      (buf_head)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      seq_d       = seq_q;
      act_d       = act_q;
      err_d       = err_q | (accept & (cmd_in.channel > MAX_CH));
      rsp_valid_d = 1'b0;
      rsp_ch_d    = rsp_ch_q;
      rsp_data_d  = rsp_data_q;
      rsp_sop_d   = rsp_sop_q;
      rsp_eop_d   = rsp_eop_q;
      buf_push    = 1'b0;
      buf_pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               act_d   = cmd_in;
               cnt_d   = CNT_LOAD;
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            buf_push = accept;
            if (cnt_q == '0) begin
               state_d     = ST_RESPOND;
               rsp_valid_d = 1'b1;
               rsp_ch_d    = act_q.channel;
               rsp_sop_d   = act_q.sop;
               rsp_eop_d   = act_q.eop;
               rsp_data_d  = rsp_word(act_q.channel, seq_q, act_q.channel <= MAX_CH);
               seq_d       = seq_q + 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESPOND: begin
            // A queued command has priority; ready is low while it is held.
            if (buf_full) begin
               buf_pop = 1'b1;
               act_d   = buf_head;
               cnt_d   = CNT_LOAD;
               state_d = ST_CONVERT;
            end else if (accept) begin
               act_d   = cmd_in;
               cnt_d   = CNT_LOAD;
               state_d = ST_CONVERT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = ~buf_full_next;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         seq_q       <= '0;
         act_q       <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ch_q    <= '0;
         rsp_data_q  <= '0;
         rsp_sop_q   <= 1'b0;
         rsp_eop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seq_q       <= seq_d;
         act_q       <= act_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ch_q    <= rsp_ch_d;
         rsp_data_q  <= rsp_data_d;
         rsp_sop_q   <= rsp_sop_d;
         rsp_eop_q   <= rsp_eop_d;
      end
   end

   assign command_ready          = ready_q;
   assign response_valid         = rsp_valid_q;
   assign response_channel       = rsp_ch_q;
   assign response_data          = rsp_data_q;
   assign response_startofpacket = rsp_sop_q;
   assign response_endofpacket   = rsp_eop_q;
   assign channel_error          = err_q;

endmodule

// File: tb/tb_mfp_adc_max10_responder.sv
// Directed bench for the ADC responder: a vector table of single commands
// plus hand-written back-to-back, seq wrap, mid-op reset and 1-cycle cases.
module tb_mfp_adc_max10_responder;

   logic        clk;
   logic        resetn;
   logic        cmd_valid, cmd_sop, cmd_eop;
   logic [4:0]  cmd_channel;
   logic        command_ready, response_valid, response_sop, response_eop, channel_error;
   logic [4:0]  response_channel;
   logic [11:0] response_data;

   logic        c1_valid, c1_sop, c1_eop;
   logic [4:0]  c1_channel;
   logic        c1_ready, c1_rvalid, c1_rsop, c1_reop, c1_err;
   logic [4:0]  c1_rchannel;
   logic [11:0] c1_rdata;

   int checks   = 0;
   int failures = 0;

   mfp_adc_max10_responder #(.CONV_CYCLES(4), .MAX_CHANNEL(17)) dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .command_valid          (cmd_valid),
      .command_channel        (cmd_channel),
      .command_startofpacket  (cmd_sop),
      .command_endofpacket    (cmd_eop),
      .command_ready          (command_ready),
      .response_valid         (response_valid),
      .response_channel       (response_channel),
      .response_data          (response_data),
      .response_startofpacket (response_sop),
      .response_endofpacket   (response_eop),
      .channel_error          (channel_error)
   );

   mfp_adc_max10_responder #(.CONV_CYCLES(1), .MAX_CHANNEL(17)) dut1 (
      .clk                    (clk),
      .resetn                 (resetn),
      .command_valid          (c1_valid),
      .command_channel        (c1_channel),
      .command_startofpacket  (c1_sop),
      .command_endofpacket    (c1_eop),
      .command_ready          (c1_ready),
      .response_valid         (c1_rvalid),
      .response_channel       (c1_rchannel),
      .response_data          (c1_rdata),
      .response_startofpacket (c1_rsop),
      .response_endofpacket   (c1_reop),
      .channel_error          (c1_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  ch;
      logic        sop;
      logic        eop;
      logic [11:0] data;
      logic        err;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset(input string nm);
      resetn = 1'b1;
      chk({nm, "_ready_before_edge"}, 32'(command_ready), 32'd0);
      tick();
      chk({nm, "_ready_after_edge"}, 32'(command_ready), 32'd1);
   endtask

   task automatic do_reset(input string nm);
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      #1;
      tick();
      tick();
      release_reset(nm);
   endtask

   // Issue one command and check result timing (CONV_CYCLES=4 instance).
   task automatic send_and_check(input string nm, input logic [4:0] ch, input logic sop,
                                 input logic eop, input logic [11:0] exp_data, input logic exp_err);
      int lat;
      lat = 0;
      for (int i = 0; i < 50 && !command_ready; i++) tick();
      chk({nm, "_ready"}, 32'(command_ready), 32'd1);
      cmd_valid = 1'b1; cmd_channel = ch; cmd_sop = sop; cmd_eop = eop;
      tick();
      cmd_valid = 1'b0; cmd_channel = 5'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (response_valid) begin
            lat = i;
            break;
         end
      end
      chk({nm, "_latency"}, 32'(lat), 32'd4);
      chk({nm, "_data"}, 32'(response_data), 32'(exp_data));
      chk({nm, "_channel"}, 32'(response_channel), 32'(ch));
      chk({nm, "_sop_eop"}, 32'({response_sop, response_eop}), 32'({sop, eop}));
      chk({nm, "_err"}, 32'(channel_error), 32'(exp_err));
      tick();
      chk({nm, "_valid_one_cycle"}, 32'(response_valid), 32'd0);
      chk({nm, "_data_held"}, 32'(response_data), 32'(exp_data));
   endtask

   initial begin
      int nresp, accepts, gap_err, last_e, lat, stray;
      int r_edge [2];
      logic [11:0] r_data [2];
      logic [4:0]  r_ch [2];
      logic [1:0]  r_se [2];

      resetn = 1'b0; cmd_valid = 1'b0; cmd_channel = '0; cmd_sop = 1'b0; cmd_eop = 1'b0;
      c1_valid = 1'b0; c1_channel = '0; c1_sop = 1'b0; c1_eop = 1'b0;

      vecs[0] = '{5'd3,  1'b1, 1'b1, 12'h180, 1'b0};
      vecs[1] = '{5'd16, 1'b0, 1'b1, 12'h801, 1'b0};
      vecs[2] = '{5'd17, 1'b1, 1'b1, 12'h882, 1'b0};
      vecs[3] = '{5'd0,  1'b0, 1'b0, 12'h003, 1'b0};
      vecs[4] = '{5'd20, 1'b1, 1'b0, 12'h000, 1'b1};
      vecs[5] = '{5'd5,  1'b1, 1'b0, 12'h285, 1'b1};
      vecs[6] = '{5'd31, 1'b0, 1'b1, 12'h000, 1'b1};
      vecs[7] = '{5'd18, 1'b0, 1'b0, 12'h000, 1'b1};
      vecs[8] = '{5'd1,  1'b1, 1'b1, 12'h088, 1'b1};

      // Reset values
      tick();
      chk("rst_outputs", 32'({command_ready, response_valid, response_sop, response_eop, channel_error}), 32'd0);
      chk("rst_chan_data", 32'({response_channel, response_data}), 32'd0);
      tick();
      release_reset("init");

      // Vector table: sequence numbers follow table order from seq=0
      for (int v = 0; v < 9; v++) begin
         send_and_check($sformatf("vec%0d", v), vecs[v].ch, vecs[v].sop, vecs[v].eop,
                        vecs[v].data, vecs[v].err);
      end

      // Reset mid-conversion with a pending command
      cmd_valid = 1'b1; cmd_channel = 5'd3; cmd_sop = 1'b1; cmd_eop = 1'b0;
      tick();
      cmd_channel = 5'd4;
      tick();
      cmd_valid = 1'b0;
      chk("midrst_pending_ready", 32'(command_ready), 32'd0);
      tick();
      resetn = 1'b0;
      #1;
      chk("midrst_outputs", 32'({command_ready, response_valid, response_sop, response_eop, channel_error}), 32'd0);
      chk("midrst_chan_data", 32'({response_channel, response_data}), 32'd0);
      tick();
      tick();
      release_reset("midrst");
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (response_valid) stray++;
      end
      chk("midrst_no_response", 32'(stray), 32'd0);
      send_and_check("midrst_next", 5'd2, 1'b0, 1'b0, 12'h100, 1'b0);

      // Back-to-back: ch1 then ch2 held valid
      do_reset("b2b");
      nresp = 0;
      cmd_valid = 1'b1; cmd_channel = 5'd1; cmd_sop = 1'b1; cmd_eop = 1'b0;
      tick();
      chk("b2b_ready_after_first", 32'(command_ready), 32'd1);
      cmd_channel = 5'd2; cmd_sop = 1'b0; cmd_eop = 1'b1;
      tick();
      cmd_valid = 1'b0; cmd_channel = 5'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
      chk("b2b_ready_dropped", 32'(command_ready), 32'd0);
      for (int e = 2; e <= 15; e++) begin
         tick();
         if (e == 5) chk("b2b_ready_after_pop", 32'(command_ready), 32'd1);
         if (response_valid) begin
            if (nresp < 2) begin
               r_edge[nresp] = e; r_data[nresp] = response_data;
               r_ch[nresp] = response_channel; r_se[nresp] = {response_sop, response_eop};
            end
            nresp++;
         end
      end
      chk("b2b_count", 32'(nresp), 32'd2);
      if (nresp >= 2) begin
         chk("b2b_first_edge", 32'(r_edge[0]), 32'd4);
         chk("b2b_spacing", 32'(r_edge[1] - r_edge[0]), 32'd5);
         chk("b2b_first_data", 32'(r_data[0]), 32'h080);
         chk("b2b_second_data", 32'(r_data[1]), 32'h101);
         chk("b2b_channels", 32'({r_ch[0], r_ch[1]}), 32'({5'd1, 5'd2}));
         chk("b2b_sop_eop", 32'({r_se[0], r_se[1]}), 32'({2'b10, 2'b01}));
      end

      // Sequence wrap: 129 commands on ch0 held back-to-back
      do_reset("wrap");
      accepts = 0; nresp = 0; gap_err = 0; last_e = 0;
      cmd_channel = 5'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
      for (int e = 0; e < 800; e++) begin
         cmd_valid = (accepts < 129);
         if (cmd_valid && command_ready) accepts++;
         tick();
         if (response_valid) begin
            nresp++;
            if (nresp == 128) chk("wrap_resp128", 32'(response_data), 32'h07F);
            if (nresp == 129) chk("wrap_resp129", 32'(response_data), 32'h000);
            if (nresp > 1 && (e - last_e) != 5) gap_err++;
            last_e = e;
            if (nresp == 129) break;
         end
      end
      cmd_valid = 1'b0;
      chk("wrap_accepts", 32'(accepts), 32'd129);
      chk("wrap_responses", 32'(nresp), 32'd129);
      chk("wrap_spacing_errors", 32'(gap_err), 32'd0);

      // CONV_CYCLES=1 instance, top in-range channel
      for (int i = 0; i < 10; i++) tick();
      chk("c1_ready", 32'(c1_ready), 32'd1);
      c1_valid = 1'b1; c1_channel = 5'd17; c1_sop = 1'b1; c1_eop = 1'b1;
      tick();
      c1_valid = 1'b0; c1_channel = 5'd0; c1_sop = 1'b0; c1_eop = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (c1_rvalid) begin
            lat = i;
            break;
         end
      end
      chk("c1_latency", 32'(lat), 32'd1);
      chk("c1_data", 32'(c1_rdata), 32'h880);
      chk("c1_channel", 32'(c1_rchannel), 32'd17);
      chk("c1_sop_eop", 32'({c1_rsop, c1_reop}), 32'({1'b1, 1'b1}));
      chk("c1_err", 32'(c1_err), 32'd0);
      tick();
      chk("c1_valid_one_cycle", 32'(c1_rvalid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
